// File: rtl/sha1_pkg.sv
// sha1_pkg: shared constants and types for the SHA-1 round sequencer and datapath
package sha1_pkg;
    localparam int ROUNDS    = 80;
    localparam int WORDS     = 16;
    localparam int PHASE_LEN = 20;

    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;
    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_RUN} state_e;

    function automatic phase_e phase_of(input logic [6:0] round);
        return round < 7'(PHASE_LEN) ? PH0 : round < 7'(2 * PHASE_LEN) ? PH1 :
               round < 7'(3 * PHASE_LEN) ? PH2 : PH3;
    endfunction
endpackage

// File: rtl/sha1_round_sequencer_if.sv
// sha1_round_sequencer_if: message stream, datapath control and result bundle
interface sha1_round_sequencer_if #(parameter int TAG_W = 8);
    import sha1_pkg::*;
    word_t            msg_data;
    logic             msg_valid;
    logic             msg_last;
    logic             msg_ready;
    word_t            dp_din;
    logic             dp_load;
    logic             dp_phase_advance;
    logic [1:0]       dp_phase;
    word_t            dp_r;
    logic             res_valid;
    word_t            res_data;
    logic [TAG_W-1:0] res_tag;

    modport master (
        input  msg_data, msg_valid, msg_last, dp_phase, dp_r,
        output msg_ready, dp_din, dp_load, dp_phase_advance, res_valid, res_data, res_tag
    );
    modport slave (
        output msg_data, msg_valid, msg_last, dp_phase, dp_r,
        input  msg_ready, dp_din, dp_load, dp_phase_advance, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/sha1_block_buffer.sv
// sha1_block_buffer: two-bank ping-pong store of 16-word blocks with framing check
module sha1_block_buffer
    import sha1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  word_t      wr_data,
    input  logic       wr_last,
    output logic       wr_full,
    input  logic       rd_release,
    input  logic [3:0] rd_idx,
    output word_t      rd_data,
    output logic       rd_full,
    output logic       rd_filling,
    output logic       frame_err
);
    word_t      mem [2][WORDS];
    logic [1:0] full;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [3:0] wr_idx;

    assign wr_full    = full[wr_ptr];
    assign rd_full    = full[rd_ptr];
    // read bank receives its last word this cycle
    assign rd_filling = wr_en && &wr_idx && wr_ptr == rd_ptr;
    assign rd_data    = mem[rd_ptr][rd_idx];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr][wr_idx] <= wr_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            full      <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_idx    <= '0;
            frame_err <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_idx <= wr_idx + 1'b1;
                if (wr_last != &wr_idx) frame_err <= 1'b1;
                if (&wr_idx) begin
                    full[wr_ptr] <= 1'b1;
                    wr_ptr       <= ~wr_ptr;
                end
            end
            if (rd_release) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
        end
endmodule

// File: rtl/sha1_round_sequencer.sv
// sha1_round_sequencer: issues buffered blocks on the 80-round schedule and captures tagged results
module sha1_round_sequencer
    import sha1_pkg::*;
#(
    parameter int TAG_W      = 8,
    parameter int RES_LAT    = 6,
    parameter int FLUSH_WAIT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    sha1_round_sequencer_if.master        bus,
    output logic                          busy,
    output logic                          err
);
    localparam int WW = $clog2(FLUSH_WAIT + 2);

    state_e           state, state_nx;
    logic [6:0]       round, round_nx;
    logic [WW-1:0]    wait_cnt;
    logic [TAG_W-1:0] tag, pend_tag;
    logic [6:0]       lat_cnt;
    logic [1:0]       ph_q;
    phase_e           exp_q1, exp_q2;
    logic             chk1, chk2, ph_err;
    logic             run, loading, last_round, flush_pulse;
    logic             wr_full, rd_full, rd_filling, frame_err;
    word_t            rd_data;

    sha1_block_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bus.msg_valid && bus.msg_ready),
        .wr_data   (bus.msg_data),
        .wr_last   (bus.msg_last),
        .wr_full   (wr_full),
        .rd_release(run && round == 7'(WORDS - 1)),
        .rd_idx    (round[3:0]),
        .rd_data   (rd_data),
        .rd_full   (rd_full),
        .rd_filling(rd_filling),
        .frame_err (frame_err)
    );

    assign run         = state == S_RUN;
    assign loading     = run && round < 7'(WORDS);
    assign last_round  = run && round == 7'(ROUNDS - 1);
    // wait_cnt starts loaded, so nothing pulses while rst is held
    assign flush_pulse = state == S_FLUSH && wait_cnt == '0 && bus.dp_phase != 2'd3;

    always_comb begin
        state_nx = state;
        round_nx = round;
        if (state == S_FLUSH) begin
            if (wait_cnt == '0 && bus.dp_phase == 2'd3) state_nx = S_IDLE;
        end else if (state == S_IDLE) begin
            if (rd_full) state_nx = S_RUN;
        end else if (last_round) begin
            state_nx = (rd_full || rd_filling) ? S_RUN : S_IDLE;
            round_nx = '0;
        end else begin
            round_nx = round + 1'b1;
        end
    end

    assign bus.msg_ready        = !wr_full && state != S_FLUSH;
    assign bus.dp_load          = loading;
    assign bus.dp_din           = loading ? rd_data : '0;
    assign bus.dp_phase_advance = flush_pulse || (run && round inside
        {7'd0, 7'(PHASE_LEN), 7'(2 * PHASE_LEN), 7'(3 * PHASE_LEN)});
    assign bus.res_valid        = lat_cnt == 7'd1;
    assign bus.res_data         = bus.res_valid ? bus.dp_r : '0;
    assign bus.res_tag          = bus.res_valid ? pend_tag : '0;
    assign busy                 = state != S_IDLE;
    assign err                  = frame_err || ph_err;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= S_FLUSH;
            round    <= '0;
            wait_cnt <= WW'(FLUSH_WAIT);
            tag      <= '0;
            pend_tag <= '0;
            lat_cnt  <= '0;
            ph_q     <= '0;
            exp_q1   <= PH0;
            exp_q2   <= PH0;
            chk1     <= 1'b0;
            chk2     <= 1'b0;
            ph_err   <= 1'b0;
        end else begin
            state <= state_nx;
            round <= round_nx;
            if (flush_pulse) wait_cnt <= WW'(FLUSH_WAIT);
            else if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            if (run && round == '0) tag <= tag + 1'b1;
            // tag already advanced at this block's round 0
            if (last_round) begin
                pend_tag <= tag - 1'b1;
                lat_cnt  <= 7'(RES_LAT);
            end else if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            ph_q   <= bus.dp_phase;
            exp_q1 <= phase_of(round);
            exp_q2 <= exp_q1;
            chk1   <= run;
            chk2   <= chk1;
            if (chk2 && ph_q != exp_q2) ph_err <= 1'b1;
        end
endmodule

// File: tb/tb_sha1_round_sequencer.sv
// tb_sha1_round_sequencer: directed checks of flush, issue schedule, back-to-back, framing and reset
module tb_sha1_round_sequencer;
    import sha1_pkg::*;
    localparam int RES_LAT    = 6;
    localparam int FLUSH_WAIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    sha1_round_sequencer_if #(.TAG_W(8)) bus ();
    sha1_round_sequencer #(.TAG_W(8), .RES_LAT(RES_LAT), .FLUSH_WAIT(FLUSH_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy),
        .err (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // datapath phase model: advance+load zeros the phase, advance alone steps it
    logic [1:0] ph;
    logic       ph_set  = 1'b1;
    logic [1:0] ph_init = 2'd1;
    always @(posedge clk)
        if (ph_set) ph <= ph_init;
        else if (bus.dp_phase_advance) ph <= bus.dp_load ? 2'd0 : ph + 2'd1;
    assign bus.dp_phase = ph;
    assign bus.dp_r     = 32'hC0DE_0000 | 32'(cyc[15:0]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    word_t      exp_q[$];
    int         r0_q[$];
    int         res_cyc_q[$];
    logic [7:0] res_tag_q[$];
    int         rnd = 0;
    bit         act = 1'b0;
    int         stall_n = 0, stall_cyc = 0, resume_cyc = 0;

    function automatic int r0_at(input int k);
        return r0_q.size() > k ? r0_q[k] : -100000;
    endfunction
    function automatic int res_at(input int k);
        return res_cyc_q.size() > k ? res_cyc_q[k] : -1;
    endfunction
    function automatic logic [7:0] tag_at(input int k);
        return res_tag_q.size() > k ? res_tag_q[k] : 8'hFF;
    endfunction

    // round monitor: every issued round is compared against the words the source sent
    always @(negedge clk) begin
        if (rst) begin
            act = 1'b0;
            exp_q.delete();
        end else begin
            if (bus.dp_load && bus.dp_phase_advance) begin
                if (act) chk("b2b_gap", rnd, 79);
                act = 1'b1;
                rnd = 0;
                r0_q.push_back(cyc);
            end else if (act) begin
                rnd++;
                if (rnd == 80) act = 1'b0;
            end
            if (act) begin
                chk("load", bus.dp_load, rnd < 16);
                chk("advance", bus.dp_phase_advance, rnd % 20 == 0);
                chk("din", bus.dp_din,
                    rnd < 16 ? (exp_q.size() != 0 ? exp_q.pop_front() : 32'hDEAD_BEEF) : 32'h0);
            end
            if (bus.res_valid) begin
                res_cyc_q.push_back(cyc);
                res_tag_q.push_back(bus.res_tag);
                chk("res_data", bus.res_data, bus.dp_r);
            end
        end
    end

    task automatic send_word(input word_t d, input logic last);
        int w = 0;
        bus.msg_valid = 1'b1;
        bus.msg_data  = d;
        bus.msg_last  = last;
        while (!bus.msg_ready && w < 400) begin
            if (w == 0) stall_cyc = cyc;
            w++;
            @(negedge clk);
        end
        chk("msg_ready", bus.msg_ready, 1'b1);
        if (w != 0) begin
            stall_n += w;
            resume_cyc = cyc;
        end
        exp_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic send_block(input word_t base);
        for (int k = 0; k < 16; k++) send_word(base + word_t'(k), k == 15);
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
    endtask

    task automatic flush_check();
        int n = 0, last = 0;
        for (int i = 0; i < 60 && !bus.msg_ready; i++) begin
            @(negedge clk);
            if (bus.dp_phase_advance) begin
                if (n > 0) chk("flush_gap", cyc - last, FLUSH_WAIT + 1);
                chk("flush_load", bus.dp_load, 1'b0);
                n++;
                last = cyc;
            end
        end
        chk("flush_pulses", n, 2);
        chk("flush_ready", bus.msg_ready, 1'b1);
        chk("flush_phase", ph, 2'd3);
        chk("flush_busy", busy, 1'b0);
    endtask

    task automatic wait_res(input int n);
        for (int i = 0; i < 400 && res_cyc_q.size() < n; i++) @(negedge clk);
        chk("res_count", res_cyc_q.size(), n);
    endtask

    initial begin
        int tgt;
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
        bus.msg_last  = 1'b0;
        repeat (2) @(negedge clk);
        ph_set = 1'b0;
        chk("rst_ready", bus.msg_ready, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_load", bus.dp_load, 1'b0);
        chk("rst_adv", bus.dp_phase_advance, 1'b0);
        chk("rst_din", bus.dp_din, 32'h0);
        chk("rst_res", bus.res_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        flush_check();

        // single block, words equal to their index
        send_block(32'h0);
        wait_res(1);
        chk("b0_lat", res_at(0) - r0_at(0), 79 + RES_LAT);
        chk("b0_tag", tag_at(0), 8'd0);
        chk("b0_err", err, 1'b0);

        // continuous stream of three blocks
        stall_n = 0;
        send_block(32'h100);
        send_block(32'h200);
        send_block(32'h300);
        wait_res(4);
        chk("d_stall_n", stall_n, 1);
        chk("d_stall_at", stall_cyc, r0_at(1) + 15);
        chk("d_resume_at", resume_cyc, r0_at(1) + 16);
        chk("d_b2b_1", r0_at(2) - r0_at(1), 80);
        chk("d_b2b_2", r0_at(3) - r0_at(2), 80);
        chk("d_lat", res_at(1) - r0_at(1), 79 + RES_LAT);
        chk("d_res_gap1", res_at(2) - res_at(1), 80);
        chk("d_res_gap2", res_at(3) - res_at(2), 80);
        chk("d_tag1", tag_at(1), 8'd1);
        chk("d_tag2", tag_at(2), 8'd2);
        chk("d_tag3", tag_at(3), 8'd3);
        chk("d_words_left", exp_q.size(), 0);
        chk("d_err", err, 1'b0);

        // msg_last on word 7 instead of word 15
        for (int k = 0; k < 16; k++) begin
            send_word(32'h400 + word_t'(k), k == 7);
            if (k == 7) chk("e_err_set", err, 1'b1);
        end
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
        wait_res(5);
        chk("e_lat", res_at(4) - r0_at(4), 79 + RES_LAT);
        chk("e_tag", tag_at(4), 8'd4);
        chk("e_err_sticky", err, 1'b1);

        // reset at round 40 of the next block
        send_block(32'h500);
        for (int i = 0; i < 300 && r0_q.size() < 6; i++) @(negedge clk);
        tgt = r0_at(5) + 40;
        for (int i = 0; i < 300 && cyc < tgt; i++) @(negedge clk);
        chk("f_at_round40", cyc, r0_at(5) + 40);
        chk("f_adv40", bus.dp_phase_advance, 1'b1);
        rst = 1'b1;
        #1;
        chk("f_load", bus.dp_load, 1'b0);
        chk("f_adv", bus.dp_phase_advance, 1'b0);
        chk("f_din", bus.dp_din, 32'h0);
        chk("f_res", bus.res_valid, 1'b0);
        chk("f_ready", bus.msg_ready, 1'b0);
        chk("f_busy", busy, 1'b1);
        chk("f_err", err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        flush_check();
        chk("f_no_res", res_cyc_q.size(), 5);
        send_block(32'h600);
        wait_res(6);
        chk("f_r0_count", r0_q.size(), 7);
        chk("f_lat", res_at(5) - r0_at(6), 79 + RES_LAT);
        chk("f_tag", tag_at(5), 8'd0);
        chk("f_err_end", err, 1'b0);
        repeat (100) @(negedge clk);
        chk("f_res_total", res_cyc_q.size(), 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
